// File: rtl/vga_scan_timing.sv
// VGA scan generator: pixel tick, x/y scan counters and a one-pixel-delayed DAC output stage.
// Optional VGA_TEST_PATTERN_EN adds pattern_sel, which replaces RGB with 8 vertical colour bars.
module vga_scan_timing #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] r_in,
    input  logic [7:0] g_in,
    input  logic [7:0] b_in,
`ifdef VGA_TEST_PATTERN_EN
    input  logic       pattern_sel,
`endif
    output logic [9:0] x_cnt,
    output logic [9:0] y_cnt,
    output logic       active,
    output logic       pix_tick,
    output logic       frame_start,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_sync_n,
    output logic       vga_clk
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_ACT_V  = 10'(H_ACTIVE);
    localparam logic [9:0]    V_ACT_V  = 10'(V_ACTIVE);
    // Sync window ends are 11 bits wide so a window ending exactly at 1024 still compares correctly.
    localparam logic [10:0]   HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0]   HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0]   VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0]   VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_scan_timing: H_TOTAL and V_TOTAL must both be <= 1024");
        end
        if (CLK_DIV < 2) begin : g_bad_div
            $error("vga_scan_timing: CLK_DIV must be >= 2");
        end
    endgenerate

    logic [DW-1:0] div_cnt;
    logic          h_wrap, v_wrap;
    logic          hs_zone, vs_zone;
    logic [7:0]    r_src, g_src, b_src;

    assign pix_tick   = (div_cnt == DIV_LAST);
    assign vga_clk    = (div_cnt >= DIV_HALF);
    assign vga_sync_n = 1'b0;
    assign active     = (x_cnt < H_ACT_V) && (y_cnt < V_ACT_V);
    assign h_wrap     = (x_cnt == H_LAST);
    assign v_wrap     = (y_cnt == V_LAST);
    assign hs_zone    = ({1'b0, x_cnt} >= HS_BEG) && ({1'b0, x_cnt} < HS_END);
    assign vs_zone    = ({1'b0, y_cnt} >= VS_BEG) && ({1'b0, y_cnt} < VS_END);

`ifdef VGA_TEST_PATTERN_EN
    generate
        if (H_ACTIVE < 8) begin : g_bad_bars
            $error("vga_scan_timing: H_ACTIVE must be >= 8 for the test pattern");
        end
    endgenerate

    localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);
    logic [2:0] bar_idx;
    // Only meaningful inside the active area, where x_cnt/BAR_W is 0..7.
    assign bar_idx = 3'(x_cnt / BAR_W);
`endif

    always_comb begin
        r_src = r_in;
        g_src = g_in;
        b_src = b_in;
`ifdef VGA_TEST_PATTERN_EN
        if (pattern_sel) begin
            r_src = {8{bar_idx[2]}};
            g_src = {8{bar_idx[1]}};
            b_src = {8{bar_idx[0]}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (pix_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt       <= '0;
            y_cnt       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_tick && h_wrap && v_wrap;
            if (pix_tick) begin
                if (h_wrap) begin
                    x_cnt <= '0;
                    y_cnt <= v_wrap ? 10'd0 : y_cnt + 10'd1;
                end else begin
                    x_cnt <= x_cnt + 10'd1;
                end
            end
        end
    end

    // Pins sample the counters as they stand on the tick, so they trail x_cnt/y_cnt by one pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
        end else if (pix_tick) begin
            vga_r       <= active ? r_src : 8'd0;
            vga_g       <= active ? g_src : 8'd0;
            vga_b       <= active ? b_src : 8'd0;
            vga_hs      <= ~hs_zone;
            vga_vs      <= ~vs_zone;
            vga_blank_n <= active;
        end
    end

endmodule

// File: tb/tb_vga_scan_timing.sv
// Self-checking bench for vga_scan_timing on a shrunken timing set; checks every cycle
// against an arithmetic model of clocks-since-reset, plus literal timing measurements.
module tb_vga_scan_timing;

    localparam int D  = 3;
    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6,  VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;   // 24
    localparam int VT = VA + VF + VS + VB;   // 12

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] r_in = '0, g_in = '0, b_in = '0;
    logic       pattern_sel = 1'b0;
    logic [9:0] x_cnt, y_cnt;
    logic       active, pix_tick, frame_start;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk;

    vga_scan_timing #(
        .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst(rst), .r_in(r_in), .g_in(g_in), .b_in(b_in),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_sel(pattern_sel),
`endif
        .x_cnt(x_cnt), .y_cnt(y_cnt), .active(active), .pix_tick(pix_tick),
        .frame_start(frame_start), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .vga_sync_n(vga_sync_n), .vga_clk(vga_clk)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Model state: clocks since reset release plus the inputs captured on the latest tick.
    int         n = 0;
    logic       mvalid = 1'b0;
    logic [7:0] lr = '0, lg = '0, lb = '0;
    logic       lps = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            n      <= 0;
            mvalid <= 1'b1;
        end else begin
            if (n % D == D - 1) begin
                lr  <= r_in;
                lg  <= g_in;
                lb  <= b_in;
`ifdef VGA_TEST_PATTERN_EN
                lps <= pattern_sel;
`else
                lps <= 1'b0;
`endif
            end
            n <= n + 1;
        end
    end

    typedef struct packed {
        logic [9:0]  x, y;
        logic        act, tick, fs, vclk;
        logic [23:0] rgb;
        logic        hs, vs, bl;
    } exp_t;

    function automatic exp_t model(input int nn, input logic [7:0] r, g, b, input logic ps);
        exp_t e;
        int p, q, xq, yq, bar;
        logic aq;
        p      = nn / D;
        e.x    = 10'(p % HT);
        e.y    = 10'((p / HT) % VT);
        e.act  = (p % HT < HA) && ((p / HT) % VT < VA);
        e.tick = (nn % D == D - 1);
        e.vclk = (nn % D >= D / 2);
        e.fs   = (nn > 0) && (nn % D == 0) && (p % (HT * VT) == 0);
        if (p == 0) begin
            e.rgb = '0; e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b0;
        end else begin
            q    = p - 1;
            xq   = q % HT;
            yq   = (q / HT) % VT;
            aq   = (xq < HA) && (yq < VA);
            e.hs = !(xq >= HA + HF && xq < HA + HF + HS);
            e.vs = !(yq >= VA + VF && yq < VA + VF + VS);
            e.bl = aq;
            if (!aq)      e.rgb = '0;
            else if (ps) begin
                bar   = xq / (HA / 8);
                e.rgb = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
            end else      e.rgb = {r, g, b};
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (mvalid) begin
            e = model(n, lr, lg, lb, lps);
            chk("x_cnt", int'(x_cnt), int'(e.x));
            chk("y_cnt", int'(y_cnt), int'(e.y));
            chk("active", int'(active), int'(e.act));
            chk("pix_tick", int'(pix_tick), int'(e.tick));
            chk("vga_clk", int'(vga_clk), int'(e.vclk));
            chk("frame_start", int'(frame_start), int'(e.fs));
            chk("rgb", int'({vga_r, vga_g, vga_b}), int'(e.rgb));
            chk("vga_hs", int'(vga_hs), int'(e.hs));
            chk("vga_vs", int'(vga_vs), int'(e.vs));
            chk("blank_n", int'(vga_blank_n), int'(e.bl));
            chk("sync_n", int'(vga_sync_n), 0);
        end
    end

    logic const_mode = 1'b0;

    task automatic step();
        @(negedge clk);
        if (const_mode) begin
            r_in = 8'hAB; g_in = 8'hCD; b_in = 8'hEF;
        end else begin
            r_in = 8'($urandom); g_in = 8'($urandom); b_in = 8'($urandom);
        end
    endtask

    task automatic wait_xy(input int x, input int y, input string name);
        int k;
        for (k = 0; k < 2 * HT * VT * D; k++) begin
            if (int'(x_cnt) == x && (y < 0 || int'(y_cnt) == y)) break;
            step();
        end
        if (k == 2 * HT * VT * D) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int fs1, hs_fall, fs2, hs_run, vs_run, hs_w, vs_w;
        fs1 = -1; hs_fall = -1; fs2 = -1;
        hs_run = 0; vs_run = 0; hs_w = -1; vs_w = -1;

        repeat (3) step();
        rst = 1'b0;

        // First hsync fall and first frame_start, counted in clocks from release.
        for (int c = 1; c <= 2000 && fs1 < 0; c++) begin
            step();
            if (!vga_hs && hs_fall < 0) hs_fall = c;
            if (frame_start) fs1 = c;
        end
        chk("first_hs_fall", hs_fall, 57);    // (16+2+1 pixels) * 3 clks
        chk("first_frame_start", fs1, 864);   // 24*12*3

        for (int k = 1; k <= 2000 && fs2 < 0; k++) begin
            step();
            if (!vga_hs) hs_run++;
            else if (hs_run > 0 && hs_w < 0) hs_w = hs_run;
            if (!vga_vs) vs_run++;
            else if (vs_run > 0 && vs_w < 0) vs_w = vs_run;
            if (frame_start) fs2 = k;
        end
        chk("frame_period", fs2, 864);
        chk("hs_low_clks", hs_w, 9);          // 3 pixels * 3 clks
        chk("vs_low_clks", vs_w, 144);        // 2 lines * 24 * 3

        // Constant colour: pins show the pixel one behind x_cnt.
        const_mode = 1'b1;
        wait_xy(1, 0, "wait_x1");
        chk("const_rgb_x0", int'({vga_r, vga_g, vga_b}), 24'hABCDEF);
        chk("const_blank_x0", int'(vga_blank_n), 1);
        wait_xy(HA + 1, 0, "wait_x17");
        chk("const_rgb_x16", int'({vga_r, vga_g, vga_b}), 0);
        chk("const_blank_x16", int'(vga_blank_n), 0);
        wait_xy(1, VA + 1, "wait_y7");
        chk("const_rgb_y6", int'({vga_r, vga_g, vga_b}), 0);
        const_mode = 1'b0;

        // Reset mid-hsync.
        wait_xy(HA + HF + 2, -1, "wait_hsync");
        chk("pre_rst_hs", int'(vga_hs), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_x", int'(x_cnt), 0);
        chk("rst_y", int'(y_cnt), 0);
        chk("rst_hs", int'(vga_hs), 1);
        chk("rst_vs", int'(vga_vs), 1);
        chk("rst_rgb", int'({vga_r, vga_g, vga_b}), 0);
        chk("rst_blank", int'(vga_blank_n), 0);
        chk("rst_fs", int'(frame_start), 0);
        repeat (3 * HT * D) step();

`ifdef VGA_TEST_PATTERN_EN
        pattern_sel = 1'b1;
        wait_xy(HA / 8 + 1, 1, "wait_bar1");
        chk("bar1_rgb", int'({vga_r, vga_g, vga_b}), 24'h0000FF);
        wait_xy(HA, 1, "wait_bar7");
        chk("bar7_rgb", int'({vga_r, vga_g, vga_b}), 24'hFFFFFF);
        repeat (HT * VT * D) step();
        pattern_sel = 1'b0;
`endif
        repeat (HT * VT * D) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
